// File: rtl/seg7_ctrl_gen.sv
// Memory-mapped multi-digit seven-segment controller: per-digit hex/raw content,
// scan multiplexing, per-digit enable/blink, PWM brightness and a status/ID register.
module seg7_ctrl_gen #(
  parameter int N_DIG     = 8,
  parameter int SCAN_DIV  = 1000,
  parameter int BLINK_DIV = 50000000,
  parameter int BRIGHT_W  = 4
) (
  input  logic             CLK100,
  input  logic             resetn,
  input  logic             req_i,
  input  logic             we_i,
  input  logic [31:0]      addr_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o,
  output logic             ack_o,
  output logic             err_o,
  output logic [6:0]       seg_o,
  output logic             dp_o,
  output logic [N_DIG-1:0] an_o
);

  localparam int SCAN_W  = $clog2(SCAN_DIV);
  localparam int BLINK_W = $clog2(BLINK_DIV);
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
  localparam logic [3:0]         IDX_LAST   = 4'(N_DIG - 1);
  localparam logic [14:0]        DIG_MASK   = 15'h7F3F;

  localparam logic [11:0] A_ENABLE = 12'h100;
  localparam logic [11:0] A_BLINK  = 12'h104;
  localparam logic [11:0] A_BRIGHT = 12'h108;
  localparam logic [11:0] A_CLEAR  = 12'h10C;
  localparam logic [11:0] A_STATUS = 12'h110;

  logic [14:0]         dig_q [N_DIG];
  logic [N_DIG-1:0]    enable_q;
  logic [N_DIG-1:0]    blink_q;
  logic [BRIGHT_W-1:0] bright_q;

  logic [SCAN_W-1:0]   scan_cnt_q;
  logic [BLINK_W-1:0]  blink_cnt_q;
  logic [BRIGHT_W-1:0] pwm_q;
  logic [3:0]          idx_q;
  logic                phase_q;

  logic [31:0]         rdata_q;
  logic                ack_q;
  logic                err_q;
  logic [6:0]          seg_q;
  logic                dp_q;
  logic [N_DIG-1:0]    an_q;

  logic [11:0]         a;
  logic                dig_hit;
  logic [31:0]         rd_data;
  logic                rd_err;

  assign a       = addr_i[11:0];
  assign dig_hit = (a[1:0] == 2'b00) && (a[11:2] < 10'(N_DIG));

  logic unused_bits;
  assign unused_bits = &{1'b0, addr_i[31:12], wdata_i, 1'b0};

  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    if (dig_hit) begin
      for (int k = 0; k < N_DIG; k++)
        if (a[11:2] == 10'(k)) rd_data = 32'(dig_q[k]);
    end else begin
      case (a)
        A_ENABLE: rd_data = 32'(enable_q);
        A_BLINK:  rd_data = 32'(blink_q);
        A_BRIGHT: rd_data = 32'(bright_q);
        A_CLEAR:  rd_data = '0;
        A_STATUS: rd_data = {19'b0, phase_q, idx_q, 8'(N_DIG)};
        default:  rd_err  = 1'b1;
      endcase
    end
  end

  // Content of the digit currently selected by the scan
  logic [14:0]      cur_dig;
  logic             cur_en;
  logic             cur_blk;
  logic             lit;
  logic [6:0]       glyph;
  logic [6:0]       seg_next;
  logic [N_DIG-1:0] an_next;

  always_comb begin
    cur_dig = '0;
    cur_en  = 1'b0;
    cur_blk = 1'b0;
    for (int k = 0; k < N_DIG; k++) begin
      if (idx_q == 4'(k)) begin
        cur_dig = dig_q[k];
        cur_en  = enable_q[k];
        cur_blk = blink_q[k];
      end
    end
  end

  assign lit = cur_en && !(cur_blk && phase_q) && (pwm_q <= bright_q);

  always_comb begin
    an_next = '1;
    for (int k = 0; k < N_DIG; k++)
      if (lit && (idx_q == 4'(k))) an_next[k] = 1'b0;
  end

  always_comb begin
    case (cur_dig[3:0])
      4'h0: glyph = 7'h01;
      4'h1: glyph = 7'h4F;
      4'h2: glyph = 7'h12;
      4'h3: glyph = 7'h06;
      4'h4: glyph = 7'h4C;
      4'h5: glyph = 7'h24;
      4'h6: glyph = 7'h20;
      4'h7: glyph = 7'h0F;
      4'h8: glyph = 7'h00;
      4'h9: glyph = 7'h04;
      4'hA: glyph = 7'h08;
      4'hB: glyph = 7'h60;
      4'hC: glyph = 7'h31;
      4'hD: glyph = 7'h42;
      4'hE: glyph = 7'h30;
      default: glyph = 7'h38;
    endcase
  end

  assign seg_next = cur_dig[5] ? ~cur_dig[14:8] : glyph;

  always_ff @(posedge CLK100) begin
    if (!resetn) begin
      for (int k = 0; k < N_DIG; k++) dig_q[k] <= '0;
      enable_q    <= '0;
      blink_q     <= '0;
      bright_q    <= '1;
      scan_cnt_q  <= '0;
      blink_cnt_q <= '0;
      pwm_q       <= '0;
      idx_q       <= '0;
      phase_q     <= 1'b0;
      rdata_q     <= '0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      seg_q       <= 7'h7F;
      dp_q        <= 1'b1;
      an_q        <= '1;
    end else begin
      ack_q   <= req_i;
      err_q   <= req_i && rd_err;
      rdata_q <= (req_i && !we_i) ? rd_data : '0;

      if (req_i && we_i) begin
        if (dig_hit) begin
          for (int k = 0; k < N_DIG; k++)
            if (a[11:2] == 10'(k)) dig_q[k] <= wdata_i[14:0] & DIG_MASK;
        end
        case (a)
          A_ENABLE: enable_q <= wdata_i[N_DIG-1:0];
          A_BLINK:  blink_q  <= wdata_i[N_DIG-1:0];
          A_BRIGHT: bright_q <= wdata_i[BRIGHT_W-1:0];
          A_CLEAR: begin
            for (int k = 0; k < N_DIG; k++) dig_q[k] <= '0;
            blink_q  <= '0;
            bright_q <= '1;
            enable_q <= '1;
          end
          default: ;
        endcase
      end

      // Counters keep running through CLEAR
      pwm_q <= pwm_q + 1'b1;
      if (scan_cnt_q == SCAN_LAST) begin
        scan_cnt_q <= '0;
        idx_q      <= (idx_q == IDX_LAST) ? 4'd0 : idx_q + 4'd1;
      end else begin
        scan_cnt_q <= scan_cnt_q + 1'b1;
      end
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_q <= '0;
        phase_q     <= ~phase_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + 1'b1;
      end

      seg_q <= seg_next;
      dp_q  <= ~cur_dig[4];
      an_q  <= an_next;
    end
  end

  assign rdata_o = rdata_q;
  assign ack_o   = ack_q;
  assign err_o   = err_q;
  assign seg_o   = seg_q;
  assign dp_o    = dp_q;
  assign an_o    = an_q;

endmodule

// File: tb/tb_seg7_ctrl_gen.sv
// Directed bench for seg7_ctrl_gen with N_DIG=4, SCAN_DIV=4, BLINK_DIV=64, BRIGHT_W=2.
// Scan position is derived from the number of clock edges since reset release.
module tb_seg7_ctrl_gen;

  logic        CLK100 = 1'b0;
  logic        resetn = 1'b0;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic [31:0] rdata_o;
  logic        ack_o;
  logic        err_o;
  logic [6:0]  seg_o;
  logic        dp_o;
  logic [3:0]  an_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  seg7_ctrl_gen #(.N_DIG(4), .SCAN_DIV(4), .BLINK_DIV(64), .BRIGHT_W(2)) dut (
    .CLK100(CLK100), .resetn(resetn), .req_i(req_i), .we_i(we_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o), .ack_o(ack_o),
    .err_o(err_o), .seg_o(seg_o), .dp_o(dp_o), .an_o(an_o)
  );

  always #5 CLK100 = ~CLK100;

  task automatic tick;
    @(posedge CLK100);
    #1;
    cyc++;
  endtask

  // One transaction followed by one idle cycle; results sampled after each edge.
  task automatic bus(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                     output logic [31:0] rd, output logic ack, output logic err,
                     output logic ack2);
    req_i = 1'b1; we_i = we; addr_i = addr; wdata_i = wd;
    tick;
    rd = rdata_o; ack = ack_o; err = err_o;
    req_i = 1'b0; we_i = 1'b0;
    tick;
    ack2 = ack_o;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] wd);
    logic [31:0] rd;
    logic ack, err, ack2;
    bus(1'b1, addr, wd, rd, ack, err, ack2);
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h110;
    repeat (3) tick;
    req_i = 1'b0;
    checks++;
    if (seg_o !== 7'h7F || dp_o !== 1'b1 || an_o !== 4'hF || ack_o !== 1'b0 ||
        err_o !== 1'b0 || rdata_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs got seg=%h dp=%b an=%h ack=%b err=%b rd=%h want 7f 1 f 0 0 0",
               seg_o, dp_o, an_o, ack_o, err_o, rdata_o);
    end
    resetn = 1'b1;
    cyc = 0;
    for (int i = 0; i < 12; i++) begin
      tick;
      checks++;
      if (an_o !== 4'hF) begin
        errors++;
        $display("FAIL reset_disabled cyc=%0d got an=%h want f", cyc, an_o);
      end
    end
  endtask

  task automatic test_bus;
    logic [31:0] rd;
    logic ack, err, ack2;
    int m;
    bus(1'b1, 32'h008, 32'h0000001A, rd, ack, err, ack2);
    checks++;
    if (ack !== 1'b1 || err !== 1'b0 || rd !== 32'h0 || ack2 !== 1'b0) begin
      errors++;
      $display("FAIL wr_digit2 got ack=%b err=%b rd=%h ack2=%b want 1 0 0 0", ack, err, rd, ack2);
    end
    bus(1'b0, 32'h008, 32'h0, rd, ack, err, ack2);
    checks++;
    if (ack !== 1'b1 || err !== 1'b0 || rd !== 32'h1A || ack2 !== 1'b0) begin
      errors++;
      $display("FAIL rd_digit2 got ack=%b err=%b rd=%h ack2=%b want 1 0 1a 0", ack, err, rd, ack2);
    end
    wr(32'h004, 32'hFFFF_FFFF);
    bus(1'b0, 32'h004, 32'h0, rd, ack, err, ack2);
    checks++;
    if (rd !== 32'h7F3F || err !== 1'b0) begin
      errors++;
      $display("FAIL rd_digit1_mask got rd=%h err=%b want 7f3f 0", rd, err);
    end
    bus(1'b0, 32'h200, 32'h0, rd, ack, err, ack2);
    checks++;
    if (ack !== 1'b1 || err !== 1'b1 || rd !== 32'h0) begin
      errors++;
      $display("FAIL rd_unmapped got ack=%b err=%b rd=%h want 1 1 0", ack, err, rd);
    end
    bus(1'b0, 32'h001, 32'h0, rd, ack, err, ack2);
    checks++;
    if (err !== 1'b1 || rd !== 32'h0) begin
      errors++;
      $display("FAIL rd_unaligned got err=%b rd=%h want 1 0", err, rd);
    end
    bus(1'b1, 32'h0F0, 32'h1, rd, ack, err, ack2);
    checks++;
    if (ack !== 1'b1 || err !== 1'b1) begin
      errors++;
      $display("FAIL wr_unmapped got ack=%b err=%b want 1 1", ack, err);
    end
    bus(1'b0, 32'h108, 32'h0, rd, ack, err, ack2);
    checks++;
    if (rd !== 32'h3) begin
      errors++;
      $display("FAIL rd_bright_reset got %h want 3", rd);
    end
    bus(1'b0, 32'h100, 32'h0, rd, ack, err, ack2);
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL rd_enable_reset got %h want 0", rd);
    end
    bus(1'b1, 32'h110, 32'hFFFF_FFFF, rd, ack, err, ack2);
    checks++;
    if (ack !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL wr_status got ack=%b err=%b want 1 0", ack, err);
    end
    m = cyc;
    bus(1'b0, 32'h110, 32'h0, rd, ack, err, ack2);
    checks++;
    if (rd !== {19'b0, 1'((m / 64) % 2), 4'((m / 4) % 4), 8'd4} || err !== 1'b0) begin
      errors++;
      $display("FAIL rd_status got rd=%h err=%b want %h 0", rd, err,
               {19'b0, 1'((m / 64) % 2), 4'((m / 4) % 4), 8'd4});
    end
    bus(1'b0, 32'h10C, 32'h0, rd, ack, err, ack2);
    checks++;
    if (rd !== 32'h0 || err !== 1'b0) begin
      errors++;
      $display("FAIL rd_clear got rd=%h err=%b want 0 0", rd, err);
    end
  endtask

  task automatic test_back_to_back;
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h00C; wdata_i = 32'h5;
    tick;
    checks++;
    if (ack_o !== 1'b1 || rdata_o !== 32'h0) begin
      errors++;
      $display("FAIL b2b_write got ack=%b rd=%h want 1 0", ack_o, rdata_o);
    end
    we_i = 1'b0;
    tick;
    checks++;
    if (ack_o !== 1'b1 || rdata_o !== 32'h5 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_read got ack=%b rd=%h err=%b want 1 5 0", ack_o, rdata_o, err_o);
    end
    req_i = 1'b0;
    tick;
    checks++;
    if (ack_o !== 1'b0 || rdata_o !== 32'h0) begin
      errors++;
      $display("FAIL b2b_idle got ack=%b rd=%h want 0 0", ack_o, rdata_o);
    end
  endtask

  task automatic test_scan_decode;
    logic [6:0] seg_exp [4];
    logic       dp_exp [4];
    int k, ix;
    seg_exp = '{7'h4F, 7'h12, 7'h06, 7'h06};
    dp_exp  = '{1'b1, 1'b1, 1'b1, 1'b0};
    wr(32'h10C, 32'h0);
    wr(32'h000, 32'h1);
    wr(32'h004, 32'h2);
    wr(32'h008, 32'h3);
    wr(32'h00C, 32'h13);
    for (int i = 0; i < 32; i++) begin
      tick;
      k = cyc - 1;
      ix = (k / 4) % 4;
      checks++;
      if (an_o !== ~(4'b0001 << ix) || seg_o !== seg_exp[ix] || dp_o !== dp_exp[ix]) begin
        errors++;
        $display("FAIL scan cyc=%0d got an=%h seg=%h dp=%b want %h %h %b", cyc, an_o, seg_o,
                 dp_o, ~(4'b0001 << ix), seg_exp[ix], dp_exp[ix]);
      end
    end
  endtask

  task automatic test_raw_enable;
    int ix;
    wr(32'h004, 32'h00007F20);
    wr(32'h100, 32'h2);
    for (int i = 0; i < 32; i++) begin
      tick;
      ix = ((cyc - 1) / 4) % 4;
      checks++;
      if (an_o !== ((ix == 1) ? 4'hD : 4'hF) ||
          (ix == 1 && (seg_o !== 7'h00 || dp_o !== 1'b1))) begin
        errors++;
        $display("FAIL raw_enable cyc=%0d got an=%h seg=%h dp=%b want %h 00 1", cyc, an_o, seg_o,
                 dp_o, (ix == 1) ? 4'hD : 4'hF);
      end
    end
  endtask

  task automatic test_blink;
    int k;
    logic [3:0] exp_an;
    wr(32'h100, 32'h1);
    wr(32'h104, 32'h1);
    for (int i = 0; i < 256; i++) begin
      tick;
      k = cyc - 1;
      exp_an = (((k / 4) % 4 == 0) && ((k / 64) % 2 == 0)) ? 4'hE : 4'hF;
      checks++;
      if (an_o !== exp_an) begin
        errors++;
        $display("FAIL blink cyc=%0d got an=%h want %h", cyc, an_o, exp_an);
      end
    end
  endtask

  task automatic test_brightness;
    int k;
    logic [3:0] exp_an;
    wr(32'h104, 32'h0);
    for (int b = 0; b < 2; b++) begin
      wr(32'h108, 32'(b));
      for (int i = 0; i < 32; i++) begin
        tick;
        k = cyc - 1;
        exp_an = (((k / 4) % 4 == 0) && (k % 4 <= b)) ? 4'hE : 4'hF;
        checks++;
        if (an_o !== exp_an) begin
          errors++;
          $display("FAIL bright%0d cyc=%0d got an=%h want %h", b, cyc, an_o, exp_an);
        end
      end
    end
    wr(32'h108, 32'h3);
  endtask

  task automatic test_live_update;
    int guard;
    wr(32'h000, 32'h0);
    guard = 0;
    while ((cyc % 16) != 1 && guard < 32) begin
      tick;
      guard++;
    end
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h000; wdata_i = 32'h8;
    tick;
    req_i = 1'b0; we_i = 1'b0;
    checks++;
    if (seg_o !== 7'h01 || an_o !== 4'hE || ack_o !== 1'b1) begin
      errors++;
      $display("FAIL live_before got seg=%h an=%h ack=%b want 01 e 1", seg_o, an_o, ack_o);
    end
    tick;
    checks++;
    if (seg_o !== 7'h00 || an_o !== 4'hE) begin
      errors++;
      $display("FAIL live_after got seg=%h an=%h want 00 e", seg_o, an_o);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd;
    logic ack, err, ack2;
    resetn = 1'b0;
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h000; wdata_i = 32'h5;
    tick;
    req_i = 1'b0; we_i = 1'b0;
    checks++;
    if (ack_o !== 1'b0 || an_o !== 4'hF || seg_o !== 7'h7F || dp_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid got ack=%b an=%h seg=%h dp=%b want 0 f 7f 1", ack_o, an_o, seg_o, dp_o);
    end
    tick;
    resetn = 1'b1;
    cyc = 0;
    tick;
    checks++;
    if (ack_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_noack got ack=%b want 0", ack_o);
    end
    bus(1'b0, 32'h000, 32'h0, rd, ack, err, ack2);
    checks++;
    if (rd !== 32'h0 || ack !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_digit0 got rd=%h ack=%b want 0 1", rd, ack);
    end
  endtask

  initial begin
    test_reset;
    test_bus;
    test_back_to_back;
    test_scan_decode;
    test_raw_enable;
    test_blink;
    test_brightness;
    test_live_update;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
